fifo_channel_buffer: RTL
========================

// Module: fifo_channel_buffer
// PURPOSE
//  Two-channel sample buffer that answers the load/read controller's handshake.
//  - Takes a sample from channel 1 or channel 2, as chosen by Mux, on every accepted Write.
//  - Returns samples in FIFO order on Read.
//  - Reports Full/Empty back to the controller: Full ends the load phase, Empty ends the drain phase.
//  - Sits between the channel front-ends and the downstream frame consumer.
// PARAMETERS
//  DATA_WIDTH  16  width of each channel sample and of Data_Out
//  ADDR_WIDTH  4   log2 of depth; DEPTH = 2**ADDR_WIDTH = 16 entries
// PORTS
//  clk         in   1             single clock, rising edge
//  reset       in   1             asynchronous, active-low reset
//  Mux         in   1             source select: 1 = Ch1_Data, 0 = Ch2_Data
//  Write       in   1             write request, level, one entry per cycle
//  Read        in   1             read request, level, one entry per cycle
//  Ch1_Data    in   DATA_WIDTH    channel 1 sample
//  Ch2_Data    in   DATA_WIDTH    channel 2 sample
//  Data_Out    out  DATA_WIDTH    registered read data
//  Data_Valid  out  1             high for one cycle when Data_Out carries a new entry
//  Full        out  1             Count == DEPTH
//  Empty       out  1             Count == 0
//  Count       out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
//  Overflow    out  1             sticky: a Write was attempted while Full
//  Underflow   out  1             sticky: a Read was attempted while Empty
// BEHAVIOUR
//  Reset (async, reset==0), forced immediately, mid-operation included:
//  - wr_ptr = rd_ptr = 0, Count = 0.
//  - Empty = 1, Full = 0.
//  - Data_Out = 0, Data_Valid = 0, Overflow = 0, Underflow = 0.
//  - Stored RAM contents are don't-care.
//  Accept rules, using flags as they stand before the edge:
//  - wr_en = Write & ~Full; rd_en = Read & ~Empty.
//  - Write data = Mux ? Ch1_Data : Ch2_Data, sampled at the accepting edge.
//  Pointers:
//  - ADDR_WIDTH bits each; increment by 1 per accepted op; wrap DEPTH-1 -> 0.
//  Count:
//  - +1 when wr_en only; -1 when rd_en only; unchanged when both or neither.
//  - Never leaves the range 0..DEPTH.
//  Flags:
//  - Full and Empty are decoded from the registered Count.
//  - Both update in the same cycle as Count; no extra lag.
//  Read latency = 1:
//  - The entry at rd_ptr appears on Data_Out with Data_Valid=1 in the cycle after the rd_en edge.
//  - Data_Out holds its value when no read is accepted; Data_Valid returns to 0.
//  Simultaneous Read & Write:
//  - Not empty, not full: both accepted; Count holds.
//  - Empty: write only. No read-through; the new entry is readable from the next cycle.
//  - Full: read only. The write is dropped and Overflow is set.
//  Error flags:
//  - Overflow sets on Write & Full; Underflow sets on Read & Empty.
//  - Both clear only on reset.
//  - Rejected operations never modify pointers, Count or RAM.
//  Mux may change on any cycle; it only matters on cycles where wr_en=1.
// STRUCTURE
//  - Shared package fifo_pkg: DATA_WIDTH and ADDR_WIDTH defaults, DEPTH localparam,
//    and the Mux select encoding constants SEL_CH1=1'b1, SEL_CH2=1'b0.
//  - Sub-module fifo_dp_ram: simple dual-port RAM.
//    - Synchronous write port (wr_en, wr_addr, wr_data).
//    - Synchronous registered read port (rd_en, rd_addr, rd_data).
//    - No reset on the array.
//  - Top level holds the input mux, the pointers, Count, flag decode,
//    Data_Valid, and the sticky error registers.
// TESTING
//  1. Reset, then write Ch1 0x0001..0x0003 (Mux=1) and Ch2 0x0A00 (Mux=0), then read 4
//     -> Data_Out 0x0001,0x0002,0x0003,0x0A00, each one cycle after its read; Empty=1 at end.
//  2. Write 16 entries -> Full=1 and Count=16 on the cycle after the 16th write.
//     A 17th write -> dropped, Overflow=1, Count stays 16.
//  3. Read from empty after reset -> Underflow=1, Data_Valid=0, Data_Out=0, Count=0.
//  4. Fill 8, then assert Read & Write together for 20 cycles -> Count stays 8, order preserved.
//     Pointers wrap past 15 with no data loss.
//  5. Full, then Read & Write together -> read accepted, write dropped, Overflow=1, Count=15.
//     Empty, then Read & Write together -> write accepted, Underflow=1, Count=1.
//  6. Drop reset low mid-burst with Count=5 -> outputs go to reset values asynchronously, before the next edge.
//     Write 0x1234 after release -> it reads back first.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the two-channel sample buffer: default geometry and
// the channel select encoding driven on Mux.
package fifo_pkg;

   localparam int FIFO_DATA_WIDTH = 16;
   localparam int FIFO_ADDR_WIDTH = 4;
   localparam int FIFO_DEPTH      = 2 ** FIFO_ADDR_WIDTH;

   localparam logic SEL_CH1 = 1'b1;
   localparam logic SEL_CH2 = 1'b0;

endpackage : fifo_pkg

// File: rtl/fifo_channel_buffer_if.sv
// Handshake between the load/read controller and the sample buffer.
// The master drives requests and channel data; the slave is the buffer itself.
interface fifo_channel_buffer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
);

   logic                  Mux;
   logic                  Write;
   logic                  Read;
   logic [DATA_WIDTH-1:0] Ch1_Data;
   logic [DATA_WIDTH-1:0] Ch2_Data;
   logic [DATA_WIDTH-1:0] Data_Out;
   logic                  Data_Valid;
   logic                  Full;
   logic                  Empty;
   logic [ADDR_WIDTH:0]   Count;
   logic                  Overflow;
   logic                  Underflow;

   modport master (
      output Mux, Write, Read, Ch1_Data, Ch2_Data,
      input  Data_Out, Data_Valid, Full, Empty, Count, Overflow, Underflow
   );

   modport slave (
      input  Mux, Write, Read, Ch1_Data, Ch2_Data,
      output Data_Out, Data_Valid, Full, Empty, Count, Overflow, Underflow
   );

endinterface : fifo_channel_buffer_if

// File: rtl/fifo_dp_ram.sv
// Simple dual-port sample store: synchronous write, registered read.
// The array carries no reset so it maps onto plain RAM.
module fifo_dp_ram #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule : fifo_dp_ram

// File: rtl/fifo_channel_buffer.sv
// Two-channel FIFO sample buffer: muxes channel 1/2 into the store on accepted
// writes, returns entries in order with one-cycle read latency.
module fifo_channel_buffer
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
   input  logic clk,
   input  logic reset,
   fifo_channel_buffer_if.slave bus
);

   localparam int                DEPTH     = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] COUNT_MAX = (ADDR_WIDTH+1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count;
   logic                  full;
   logic                  empty;
   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [DATA_WIDTH-1:0] ram_rd_data;
   logic                  has_data;
   logic                  data_valid;
   logic                  overflow;
   logic                  underflow;

   assign full    = (count == COUNT_MAX);
   assign empty   = (count == '0);
   assign wr_en   = bus.Write & ~full;
   assign rd_en   = bus.Read & ~empty;
   assign wr_data = (bus.Mux == SEL_CH1) ? bus.Ch1_Data : bus.Ch2_Data;

   fifo_dp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr),
      .rd_data (ram_rd_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         data_valid <= 1'b0;
         has_data   <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
            2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
            default: count <= count;
         endcase
         data_valid <= rd_en;
         has_data   <= has_data | rd_en;
         overflow   <= overflow  | (bus.Write & full);
         underflow  <= underflow | (bus.Read & empty);
      end
   end

   // The RAM read register has no reset; has_data masks it so Data_Out reads
   // zero from reset until the first accepted read, then holds between reads.
   assign bus.Data_Out   = has_data ? ram_rd_data : '0;
   assign bus.Data_Valid = data_valid;
   assign bus.Full       = full;
   assign bus.Empty      = empty;
   assign bus.Count      = count;
   assign bus.Overflow   = overflow;
   assign bus.Underflow  = underflow;

endmodule : fifo_channel_buffer
